// File: rtl/bus_matrix_arb.sv
// bus_matrix_arb: shared address/data bus connecting NM masters to NS slaves.
// A registered arbiter grants one master at a time, with an optional hold limit.
// The top address bits select the slave. Read data returns one cycle later
// through a registered copy of the slave select.
// Optional macro BUS_RR_EN selects round-robin arbitration.
// Without it, the lowest-index requester wins (fixed priority).
module bus_matrix_arb #(
    parameter int NM       = 2,
    parameter int NS       = 4,
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NM-1:0]    M_req,
    input  logic [NM-1:0]    M_wr,
    input  logic [NM*AW-1:0] M_address,
    input  logic [NM*DW-1:0] M_dout,
    output logic [NM-1:0]    M_grant,
    output logic [DW-1:0]    M_din,
    output logic [NS-1:0]    S_sel,
    output logic [AW-1:0]    S_address,
    output logic             S_wr,
    output logic [DW-1:0]    S_din,
    input  logic [NS*DW-1:0] S_dout
);

    localparam int SB  = $clog2(NS);
    localparam int OW  = $clog2(NM);
    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [HCW-1:0] hc_q, hc_d;
    logic [NS-1:0] sel_q;
    logic [NM-1:0] others;
    logic [OW-1:0] start_idx, win_all, win_oth;
    logic          found_all, found_oth;

    // First requester found when scanning upward from start, wrapping at NM.
    function automatic logic [OW:0] pick(input logic [NM-1:0] req, input logic [OW-1:0] start);
        logic [OW:0] res;
        int          idx;
        res = '0;
        for (int k = NM - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= NM) idx = idx - NM;
            if (req[OW'(idx)]) res = {1'b1, OW'(idx)};
        end
        return res;
    endfunction

`ifdef BUS_RR_EN
    logic [OW-1:0] last_q;

    // Remember the most recent owner so the next search starts just after it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)             last_q <= OW'(NM - 1);
        else if (state_d == OWN)  last_q <= owner_d;
    end

    assign start_idx = (last_q == OW'(NM - 1)) ? '0 : last_q + 1'b1;
`else
    assign start_idx = '0;
`endif

    assign others                 = M_req & ~(NM'(1) << owner_q);
    assign {found_all, win_all}   = pick(M_req, start_idx);
    assign {found_oth, win_oth}   = pick(others, start_idx);

    // Next owner and hold count: handover, release to idle, forced re-arbitration, or hold.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hc_d    = hc_q;
        if (state_q == IDLE) begin
            if (found_all) begin
                state_d = OWN;
                owner_d = win_all;
                hc_d    = HCW'(1);
            end
        end else if (!M_req[owner_q]) begin
            if (found_oth) begin
                owner_d = win_oth;
                hc_d    = HCW'(1);
            end else begin
                state_d = IDLE;
                hc_d    = '0;
            end
        end else if ((MAX_HOLD != 0) && (hc_q >= HCW'(MAX_HOLD)) && found_oth) begin
            owner_d = win_oth;
            hc_d    = HCW'(1);
        end else if ((MAX_HOLD != 0) && (hc_q < HCW'(MAX_HOLD))) begin
            hc_d = hc_q + 1'b1;
        end
    end

    // Arbiter state and registered slave select for the read-return path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            hc_q    <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hc_q    <= hc_d;
            sel_q   <= S_sel;
        end
    end

    assign M_grant = (state_q == OWN) ? (NM'(1) << owner_q) : '0;

    // Route the granted master onto the slave side and decode the slave from the top address bits.
    always_comb begin
        S_address = '0;
        S_wr      = 1'b0;
        S_din     = '0;
        S_sel     = '0;
        if (state_q == OWN) begin
            S_address = M_address[owner_q*AW +: AW];
            S_wr      = M_wr[owner_q];
            S_din     = M_dout[owner_q*DW +: DW];
            S_sel     = NS'(1) << S_address[AW-1 -: SB];
        end
    end

    // Return the slave chosen last cycle; zero when nothing was selected.
    always_comb begin
        M_din = '0;
        for (int j = 0; j < NS; j++) begin
            if (sel_q[j]) M_din = M_din | S_dout[j*DW +: DW];
        end
    end

endmodule
